// File: rtl/svm_sequencer_if.sv
// Bundle between the dwell-time calculator, the SVM sequencer and the gate-drive stage.
// The master side supplies sector/dwell times and observes the switching pattern.
interface svm_sequencer_if #(
  parameter int TW = 15
);
  logic [2:0]    SECTOR_IN;
  logic [TW-1:0] T_0;
  logic [TW-1:0] T_1;
  logic [TW-1:0] T_2;
  logic [TW-1:0] T_7;
  logic          MODE;
  logic [2:0]    SECTOR_OUT;
  logic [2:0]    PHASE;
  logic          U_0;
  logic          U_1;
  logic          U_2;
  logic          U_7;
  logic          SYNC;
  logic          ERR;

  modport master (
    output SECTOR_IN, T_0, T_1, T_2, T_7, MODE,
    input  SECTOR_OUT, PHASE, U_0, U_1, U_2, U_7, SYNC, ERR
  );

  modport slave (
    input  SECTOR_IN, T_0, T_1, T_2, T_7, MODE,
    output SECTOR_OUT, PHASE, U_0, U_1, U_2, U_7, SYNC, ERR
  );
endinterface

// File: rtl/svm_sequencer.sv
// Centre-aligned space-vector PWM sequencer: latches dwell times once per sample
// period and emits the 7- or 5-segment switching pattern with one-hot vector flags.
module svm_sequencer #(
  parameter int TW     = 15,
  parameter int PERIOD = 10000,
  parameter int CW     = 16
) (
  input logic            CLK,
  input logic            RST,
  svm_sequencer_if.slave bus
);

  localparam int SW = TW + 2;
  localparam int XW = (CW > SW) ? CW : SW;
  localparam logic [CW-1:0] LAST  = CW'(PERIOD - 1);
  localparam logic [SW-1:0] PER_S = SW'(PERIOD);

  typedef enum logic [1:0] {SEG_V0, SEG_VA, SEG_VB, SEG_V7} seg_t;

  function automatic logic [2:0] vec_of(input logic [2:0] idx);
    case (idx)
      3'd1:    vec_of = 3'b100;
      3'd2:    vec_of = 3'b110;
      3'd3:    vec_of = 3'b010;
      3'd4:    vec_of = 3'b011;
      3'd5:    vec_of = 3'b001;
      3'd6:    vec_of = 3'b101;
      default: vec_of = 3'b000;
    endcase
  endfunction

  logic [CW-1:0] cnt;
  logic [2:0]    sec_p0;
  logic          fault_p0;
  logic [SW-1:0] b1_p0, b2_p0, b3_p0, b4_p0, b5_p0, b6_p0;

  logic [SW-1:0] sum, h0, h1, h2, h7;
  logic [SW-1:0] b1, b2, b3, b4, b5, b6;
  logic          fault;

  // Latch-time arithmetic; widths carry the full four-way sum so overruns are never masked.
  always_comb begin
    sum   = SW'(bus.T_0) + SW'(bus.T_1) + SW'(bus.T_2) + SW'(bus.T_7);
    fault = (sum > PER_S) || (bus.SECTOR_IN > 3'd5);
    h1    = SW'(bus.T_1 >> 1);
    h2    = SW'(bus.T_2 >> 1);
    if (bus.MODE) begin
      h0 = (SW'(bus.T_0) + SW'(bus.T_7)) >> 1;
      h7 = '0;
    end else begin
      h0 = SW'(bus.T_0 >> 1);
      h7 = SW'(bus.T_7 >> 1);
    end
    b1 = h0;
    b2 = b1 + h1;
    b3 = b2 + h2;
    b4 = b3 + (h7 << 1);
    b5 = b4 + h2;
    b6 = b5 + h1;
  end

  logic [XW-1:0] c;
  seg_t          seg;

  always_comb begin
    c = XW'(cnt);
    if (fault_p0 || c < XW'(b1_p0) || c >= XW'(b6_p0)) seg = SEG_V0;
    else if (c < XW'(b2_p0))                            seg = SEG_VA;
    else if (c < XW'(b3_p0))                            seg = SEG_VB;
    else if (c < XW'(b4_p0))                            seg = SEG_V7;
    else if (c < XW'(b5_p0))                            seg = SEG_VB;
    else                                                seg = SEG_VA;
  end

  logic [2:0] t1_vec, t2_vec, phase_n;
  logic [3:0] u_n;

  // Odd sectors swap Va/Vb so every boundary flips exactly one leg; u_n is {U_7,U_2,U_1,U_0}.
  always_comb begin
    t1_vec  = vec_of(sec_p0 + 3'd1);
    t2_vec  = vec_of((sec_p0 == 3'd5) ? 3'd1 : sec_p0 + 3'd2);
    phase_n = 3'b000;
    u_n     = 4'b0001;
    case (seg)
      SEG_VA: begin
        phase_n = sec_p0[0] ? t2_vec  : t1_vec;
        u_n     = sec_p0[0] ? 4'b0100 : 4'b0010;
      end
      SEG_VB: begin
        phase_n = sec_p0[0] ? t1_vec  : t2_vec;
        u_n     = sec_p0[0] ? 4'b0010 : 4'b0100;
      end
      SEG_V7: begin
        phase_n = 3'b111;
        u_n     = 4'b1000;
      end
      default: begin
        phase_n = 3'b000;
        u_n     = 4'b0001;
      end
    endcase
  end

  // Stage boundary: counter, period latch and registered outputs share one edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt            <= '0;
      sec_p0         <= '0;
      fault_p0       <= 1'b0;
      b1_p0          <= '0;
      b2_p0          <= '0;
      b3_p0          <= '0;
      b4_p0          <= '0;
      b5_p0          <= '0;
      b6_p0          <= '0;
      bus.PHASE      <= 3'b000;
      bus.U_0        <= 1'b0;
      bus.U_1        <= 1'b0;
      bus.U_2        <= 1'b0;
      bus.U_7        <= 1'b0;
      bus.SYNC       <= 1'b0;
      bus.SECTOR_OUT <= 3'd0;
      bus.ERR        <= 1'b0;
    end else begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      if (cnt == LAST) begin
        sec_p0   <= bus.SECTOR_IN;
        fault_p0 <= fault;
        b1_p0    <= b1;
        b2_p0    <= b2;
        b3_p0    <= b3;
        b4_p0    <= b4;
        b5_p0    <= b5;
        b6_p0    <= b6;
      end
      bus.PHASE <= phase_n;
      bus.U_0   <= u_n[0];
      bus.U_1   <= u_n[1];
      bus.U_2   <= u_n[2];
      bus.U_7   <= u_n[3];
      bus.SYNC  <= (cnt == '0);
      if (cnt == '0) begin
        bus.SECTOR_OUT <= sec_p0;
        bus.ERR        <= fault_p0;
      end
    end
  end

endmodule

// File: tb/tb_svm_sequencer.sv
// Scoreboard bench for svm_sequencer with PERIOD=20: directed dwell vectors, faults,
// mid-period input changes and a mid-period reset, checked every output cycle.
module tb_svm_sequencer;

  localparam int TW = 15;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  svm_sequencer_if #(.TW(TW)) bus ();

  svm_sequencer #(.TW(TW), .PERIOD(20), .CW(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Expected word: {SECTOR_OUT, ERR, SYNC, U_7, U_2, U_1, U_0, PHASE}
  logic [11:0] q[$];
  int          checks = 0;
  int          passes = 0;
  int          out_idx = 0;
  logic        timeout_flag = 1'b0;
  logic        timeout_seen = 1'b0;

  logic [2:0] cur_sec;
  logic       cur_err;
  logic       first;

  localparam logic [3:0] U0 = 4'b0001;
  localparam logic [3:0] U1 = 4'b0010;
  localparam logic [3:0] U2 = 4'b0100;
  localparam logic [3:0] U7 = 4'b1000;

  task automatic begin_period(input logic [2:0] s, input logic e);
    cur_sec = s;
    cur_err = e;
    first   = 1'b1;
  endtask

  task automatic run(input logic [2:0] ph, input logic [3:0] u, input int n);
    for (int i = 0; i < n; i++) begin
      q.push_back({cur_sec, cur_err, first, u, ph});
      first = 1'b0;
    end
  endtask

  task automatic exp_zero();
    begin_period(3'd0, 1'b0);
    run(3'b000, U0, 20);
  endtask

  task automatic exp_fault(input logic [2:0] s);
    begin_period(s, 1'b1);
    run(3'b000, U0, 20);
  endtask

  task automatic exp_a();
    begin_period(3'd0, 1'b0);
    run(3'b000, U0, 2); run(3'b100, U1, 3); run(3'b110, U2, 2); run(3'b111, U7, 6);
    run(3'b110, U2, 2); run(3'b100, U1, 3); run(3'b000, U0, 2);
  endtask

  task automatic exp_b(input int n_cycles);
    begin_period(3'd1, 1'b0);
    if (n_cycles == 20) begin
      run(3'b000, U0, 2); run(3'b010, U2, 3); run(3'b110, U1, 2); run(3'b111, U7, 6);
      run(3'b110, U1, 2); run(3'b010, U2, 3); run(3'b000, U0, 2);
    end else begin
      run(3'b000, U0, 2); run(3'b010, U2, 3); run(3'b110, U1, 2); run(3'b111, U7, 2);
    end
  endtask

  task automatic exp_c();
    begin_period(3'd2, 1'b0);
    run(3'b000, U0, 5); run(3'b010, U1, 2); run(3'b011, U2, 4);
    run(3'b010, U1, 2); run(3'b000, U0, 7);
  endtask

  task automatic exp_h();
    begin_period(3'd0, 1'b0);
    run(3'b000, U0, 2); run(3'b100, U1, 1); run(3'b110, U2, 2); run(3'b111, U7, 6);
    run(3'b110, U2, 2); run(3'b100, U1, 1); run(3'b000, U0, 6);
  endtask

  task automatic set_in(input logic [2:0] s, input int t0, input int t1,
                        input int t2, input int t7, input logic m);
    bus.SECTOR_IN = s;
    bus.T_0 = TW'(t0);
    bus.T_1 = TW'(t1);
    bus.T_2 = TW'(t2);
    bus.T_7 = TW'(t7);
    bus.MODE = m;
  endtask

  // Vector table: 0=A sec0, 1=B sec1, 2=C sec2 mode1, 3=overrun, 4=sector 7, 5=H (A with new T_1)
  task automatic set_vec(input int v);
    case (v)
      0: set_in(3'd0, 4, 6, 4, 6, 1'b0);
      1: set_in(3'd1, 4, 6, 4, 6, 1'b0);
      2: set_in(3'd2, 4, 5, 4, 6, 1'b1);
      3: set_in(3'd0, 10, 6, 4, 6, 1'b0);
      4: set_in(3'd7, 4, 6, 4, 6, 1'b0);
      default: set_in(3'd0, 4, 2, 4, 6, 1'b0);
    endcase
  endtask

  // Push this period's expectation, then change inputs mid-period for the next one.
  task automatic period(input int next_vec);
    repeat (10) @(posedge CLK);
    #1;
    set_vec(next_vec);
    repeat (10) @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    logic [11:0] exp_w, act;
    if (q.size() != 0) begin
      exp_w = q.pop_front();
      act = {bus.SECTOR_OUT, bus.ERR, bus.SYNC, bus.U_7, bus.U_2, bus.U_1, bus.U_0, bus.PHASE};
      checks++;
      if (act === exp_w) passes++;
      else
        $display("FAIL out#%0d sec/err/sync/u7u2u1u0/phase got %0d/%b/%b/%b/%b required %0d/%b/%b/%b/%b",
                 out_idx, act[11:9], act[8], act[7], act[6:3], act[2:0],
                 exp_w[11:9], exp_w[8], exp_w[7], exp_w[6:3], exp_w[2:0]);
      out_idx++;
    end
    if (timeout_flag && !timeout_seen) begin
      timeout_seen = 1'b1;
      checks++;
      $display("FAIL drain scoreboard still holds %0d entries, required 0", q.size());
    end
  end

  initial begin
    set_in(3'd0, 0, 0, 0, 0, 1'b0);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    cur_sec = 3'd0; cur_err = 1'b0; first = 1'b0;
    run(3'b000, 4'b0000, 1);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    exp_zero();  period(0);
    exp_a();     period(1);
    exp_b(20);   period(2);
    exp_c();     period(3);
    exp_fault(3'd0); period(0);
    exp_a();     period(4);
    exp_fault(3'd7); period(0);
    exp_a();     period(5);
    exp_h();     period(1);

    // Partial sector-1 period, then reset sampled at the CNT=9 edge.
    exp_b(9);
    cur_sec = 3'd0; cur_err = 1'b0; first = 1'b0;
    run(3'b000, 4'b0000, 1);
    repeat (8) @(posedge CLK);
    #1;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    set_vec(2);
    exp_zero();
    exp_c();

    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge CLK);
    if (q.size() != 0) timeout_flag = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/svm_sequencer.md
Name: svm_sequencer

Overview:
- Parametrised space-vector PWM sequencer for the AC motor vector path.
- Takes per-period dwell times and the sector, and produces a centre-aligned switching pattern every sample period.
- Drives three-phase switch states plus one-hot vector flags.
- Supports selectable 7-segment (symmetric V0/V7) or 5-segment (V0-clamped) modulation, plus overrun and illegal-sector detection. Sits between the dwell-time calculator and the gate driver / dead-time stage.

Parameters:
TW, 15, width of dwell-time inputs (clock cycles)
PERIOD, 10000, sample period in clock cycles (f_clk / f_tast); must be ≥ 2 and < 2^(TW+2)
CW, 16, period counter width; must satisfy 2^CW > PERIOD

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
SECTOR_IN  in  3  sector 0..5; 6 and 7 are illegal
T_0  in  TW  zero-vector V0 dwell per period
T_1  in  TW  dwell of first adjacent active vector V(s+1)
T_2  in  TW  dwell of second adjacent active vector V((s+1) mod 6 + 1)
T_7  in  TW  zero-vector V7 dwell per period
MODE  in  1  0 = 7-segment symmetric, 1 = 5-segment V0-clamped
SECTOR_OUT  out  3  sector applied in current period
PHASE  out  3  switch states {A,B,C}, 1 = upper switch on
U_0  out  1  V0 (000) active
U_1  out  1  T_1 vector active
U_2  out  1  T_2 vector active
U_7  out  1  V7 (111) active
SYNC  out  1  one-cycle pulse on first output cycle of each period
ERR  out  1  current period is faulted (overrun or illegal sector)

Behaviour:
- Clock and reset: single clock CLK. RST is synchronous and active-high. All state is updated on the CLK rising edge.
- Reset values: CNT = 0; all latched registers = 0; PHASE = 000; U_0/U_1/U_2/U_7 = 0; SECTOR_OUT = 0; SYNC = 0; ERR = 0.
- Reset mid-period: pattern is abandoned. The first full period after release uses the zeroed latch, so the whole period is V0 (U_0 = 1).
- Period counter CNT: runs 0..PERIOD-1 and wraps to 0.
- Input latch: when CNT == PERIOD-1, latch SECTOR_IN, T_0, T_1, T_2, T_7, MODE. They take effect from CNT == 0. Input changes at any other time are ignored.
- Sum check, at latch time: S = T_0+T_1+T_2+T_7, computed in TW+2 bits with no truncation. Fault = (S > PERIOD) or (SECTOR_IN > 5).
- Half-times: h1 = T_1>>1, h2 = T_2>>1.
  - MODE 0: h0 = T_0>>1, h7 = T_7>>1.
  - MODE 1: h0 = (T_0+T_7)>>1, h7 = 0.
  - Odd-value truncation is absorbed by extra tail V0.
- Segment thresholds, registered at latch time in TW+2 bits:
  - b1 = h0
  - b2 = b1+h1
  - b3 = b2+h2
  - b4 = b3+2·h7
  - b5 = b4+h2
  - b6 = b5+h1
- Segment selection for count c:
  - c < b1: V0
  - b1 ≤ c < b2: Va
  - b2 ≤ c < b3: Vb
  - b3 ≤ c < b4: V7
  - b4 ≤ c < b5: Vb
  - b5 ≤ c < b6: Va
  - c ≥ b6: V0
  - Empty segments are skipped; two adjacent equal thresholds produce no glitch.
- Vector order by sector:
  - Even sector: Va = T_1 vector, Vb = T_2 vector.
  - Odd sector: Va = T_2 vector, Vb = T_1 vector.
  - This ordering gives exactly one phase toggle per segment boundary.
- Vector table {A,B,C}: V1=100, V2=110, V3=010, V4=011, V5=001, V6=101, V0=000, V7=111.
  - Sector s: T_1 vector = V(s+1), T_2 vector = V((s+1) mod 6 + 1).
- Output flags: U_* are one-hot and follow the segment (U_1 marks the T_1 vector, not position). Exactly one U_* is high whenever out of reset and past the first output cycle.
- Faulted period: PHASE = 000 and U_0 = 1 for the entire period; ERR = 1 for that period only, and clears on the next non-faulted period. SECTOR_OUT still shows the latched value.
- Latency: outputs are registered, one cycle after CNT. The output cycle after the edge where CNT = c shows segment(c). SYNC = 1 on the output cycle for c = 0. SECTOR_OUT and ERR update on the same cycle as SYNC.

Test Plan:
- PERIOD=20, MODE=0, sector 0, T=(4,6,4,6) → per period PHASE 000×2, 100×3, 110×2, 111×6, 110×2, 100×3, 000×2; SYNC each 20 cycles; ERR=0.
- Same times, sector 1 → 000×2, 010×3 (U_2), 110×2 (U_1), 111×6, 110×2, 010×3, 000×2.
- PERIOD=20, MODE=1, sector 2, T=(4,5,4,6) → h0=5, h1=2 → 000×5, 010×2, 011×2, 011×2, 010×2, 000×7; U_7 never high.
- Overrun: T=(10,6,4,6) (S=26 > 20) → whole period 000 with U_0=1 and ERR=1; next legal period has ERR=0 and a normal pattern.
- Illegal sector 7 → faulted period, same as overrun. Changing T_1 mid-period does not alter the current period; the change takes effect at the next SYNC.
- Assert RST at CNT=9 of an active period → next cycle PHASE=000, all U_*=0, SYNC=0. After release, the first period is all V0, then latched inputs apply.
